// File: rtl/key_loader_32_if.sv
// Serial key-load bus between a key source (master) and key_loader_32 (slave).
interface key_loader_32_if #(
  parameter int KEY_W = 32
);
  logic             load_start;
  logic             key_sin;
  logic             key_sin_valid;
  logic             key_sin_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;

  modport master (
    output load_start, key_sin, key_sin_valid,
    input  key_sin_ready, key_out, key_valid, busy, err
  );

  modport slave (
    input  load_start, key_sin, key_sin_valid,
    output key_sin_ready, key_out, key_valid, busy, err
  );
endinterface

// File: rtl/key_loader_32.sv
// Serial LSB-first key loader for a logic-locked netlist; the key bus only changes on a checked frame.
// Optional even-parity frame check is enabled with `define KEY_LOADER_PARITY_EN.
module key_loader_32 #(
  parameter int KEY_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  key_loader_32_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_APPLIED = 2'd3;

`ifdef KEY_LOADER_PARITY_EN
  localparam int FRAME_LEN = KEY_W + 1;
`else
  localparam int FRAME_LEN = KEY_W;
`endif
  localparam int CNT_W = $clog2(KEY_W + 2);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_shadow;
  logic [KEY_W-1:0] r_key;
  logic             r_key_valid;
  logic             r_ready;
  logic             r_busy;
  logic             w_accept;
  logic             w_last;
  logic             w_check_ok;

  assign w_accept = bus.key_sin_valid & r_ready;
  assign w_last   = w_accept && (r_cnt == CNT_W'(FRAME_LEN - 1));

`ifdef KEY_LOADER_PARITY_EN
  logic r_pbit;
  logic r_err;

  function automatic logic f_even_parity_ok(input logic [KEY_W-1:0] data, input logic pbit);
    f_even_parity_ok = ((^data) ^ pbit) == 1'b0;
  endfunction

  assign w_check_ok = f_even_parity_ok(r_shadow, r_pbit);

  // Parity bit capture and sticky error flag, cleared by an accepted load_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pbit <= 1'b0;
      r_err  <= 1'b0;
    end else if ((r_state == S_IDLE || r_state == S_APPLIED) && bus.load_start) begin
      r_pbit <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_state == S_SHIFT && w_accept && r_cnt == CNT_W'(KEY_W)) begin
      r_pbit <= bus.key_sin;
    end else if (r_state == S_CHECK && !w_check_ok) begin
      r_err  <= 1'b1;
    end else begin
      r_err  <= r_err;
    end
  end

  assign bus.err = r_err;
`else
  assign w_check_ok = 1'b1;
  assign bus.err    = 1'b0;
`endif

  // Next-state decode; load_start is only honoured outside a frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_APPLIED: begin
        if (bus.load_start) w_state_nxt = S_SHIFT;
        else                w_state_nxt = r_state;
      end
      S_SHIFT: begin
        if (w_last) w_state_nxt = S_CHECK;
        else        w_state_nxt = S_SHIFT;
      end
      S_CHECK: begin
        if (w_check_ok) w_state_nxt = S_APPLIED;
        else            w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, shadow shift register and the key bus; ready/busy are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_shadow    <= {KEY_W{1'b0}};
      r_key       <= {KEY_W{1'b0}};
      r_key_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_SHIFT);
      r_busy  <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_CHECK);
      case (r_state)
        S_IDLE, S_APPLIED: begin
          if (bus.load_start) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_shadow <= {KEY_W{1'b0}};
          end
        end
        S_SHIFT: begin
          if (w_accept) begin
            for (int i = 0; i < KEY_W; i++) begin
              if (r_cnt == CNT_W'(i)) r_shadow[i] <= bus.key_sin;
            end
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (w_check_ok) begin
            r_key       <= r_shadow;
            r_key_valid <= 1'b1;
          end else begin
            r_key       <= {KEY_W{1'b0}};
            r_key_valid <= 1'b0;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.key_sin_ready = r_ready;
  assign bus.busy          = r_busy;
  assign bus.key_out       = r_key;
  assign bus.key_valid     = r_key_valid;

endmodule

// File: tb/tb_key_loader_32.sv
// Scoreboard bench for key_loader_32: frames push their expected outcome, a monitor checks it when busy falls.
module tb_key_loader_32;
  localparam int KEY_W = 32;
`ifdef KEY_LOADER_PARITY_EN
  localparam int FL = KEY_W + 1;
`else
  localparam int FL = KEY_W;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_loader_32_if #(.KEY_W(KEY_W)) bus();
  key_loader_32 #(.KEY_W(KEY_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  int          acc    = 0;
  logic [33:0] sb_q[$];
  logic        prev_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Handshake counter, independent of the stimulus loop
  always @(posedge clk) begin
    if (rst_n && bus.key_sin_valid && bus.key_sin_ready) acc++;
  end

  // Monitor: a frame has resolved when busy falls outside reset
  initial begin
    logic [33:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !bus.busy) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%h required=none", {bus.key_out, bus.key_valid, bus.err});
          end else begin
            exp = sb_q.pop_front();
            chk("sb_result", {30'h0, bus.key_out, bus.key_valid, bus.err}, {30'h0, exp});
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic start_frame();
    @(negedge clk);
    bus.load_start    = 1'b1;
    bus.key_sin_valid = 1'b0;
    acc = 0;
    @(negedge clk);
    bus.load_start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_err_clr", bus.err, 0);
    chk("start_ready", bus.key_sin_ready, 1);
  endtask

  task automatic send_frame(input logic [31:0] key, input logic pbit, input bit gap,
                            input int ls_at, input bit hold, input logic [31:0] hold_key,
                            input logic pre_valid, input logic fin_valid);
    sb_q.push_back(fin_valid ? {key, 1'b1, 1'b0} : {32'h0, 1'b0, 1'b1});
    for (int k = 0; k < FL; k++) begin
      if (gap) begin
        bus.key_sin_valid = 1'b0;
        @(negedge clk);
      end
      bus.key_sin       = (k < KEY_W) ? key[k] : pbit;
      bus.key_sin_valid = 1'b1;
      bus.load_start    = (k == ls_at);
      if (k == 0) chk("ready_shift", bus.key_sin_ready, 1);
      if (hold) begin
        chk("hold_key", bus.key_out, hold_key);
        chk("hold_valid", bus.key_valid, 1);
      end
      @(negedge clk);
    end
    bus.key_sin_valid = 1'b0;
    bus.load_start    = 1'b0;
    chk("busy_in_check", bus.busy, 1);
    chk("kv_before_check", bus.key_valid, pre_valid);
    if (hold) chk("hold_key_check", bus.key_out, hold_key);
    @(posedge clk);
    #1;
    chk("kv_after_check", bus.key_valid, fin_valid);
    chk("bits_accepted", acc, FL);
  endtask

  initial begin
    bus.load_start    = 1'b0;
    bus.key_sin       = 1'b0;
    bus.key_sin_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key", bus.key_out, 0);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.key_sin_ready, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus.key_sin_ready, 0);

    // Even-parity key: 0xA5A5_0F0F has 16 ones
    start_frame();
    send_frame(32'hA5A5_0F0F, 1'b0, 1'b0, -1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("a5_err", bus.err, 0);

`ifdef KEY_LOADER_PARITY_EN
    // Same key with a wrong parity bit: old key is dropped, err set, back to IDLE
    start_frame();
    send_frame(32'hA5A5_0F0F, 1'b1, 1'b0, -1, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fail_err", bus.err, 1);
    chk("fail_key", bus.key_out, 0);
    chk("fail_busy", bus.busy, 0);
    chk("fail_ready", bus.key_sin_ready, 0);
`endif

    // 0x0000_0001 with a valid gap before every bit; one 1 -> parity bit 1
    start_frame();
`ifdef KEY_LOADER_PARITY_EN
    send_frame(32'h0000_0001, 1'b1, 1'b1, -1, 1'b0, 32'h0, 1'b0, 1'b1);
`else
    send_frame(32'h0000_0001, 1'b1, 1'b1, -1, 1'b0, 32'h0, 1'b1, 1'b1);
`endif
    @(negedge clk);

    // Reset after 10 accepted bits of a reload
    start_frame();
    for (int k = 0; k < 10; k++) begin
      bus.key_sin       = k[0];
      bus.key_sin_valid = 1'b1;
      @(negedge clk);
    end
    bus.key_sin_valid = 1'b0;
    chk("mid_acc", acc, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_key", bus.key_out, 0);
    chk("mid_rst_valid", bus.key_valid, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.key_sin_ready, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);

    // 0x1234_5678 has 13 ones -> parity bit 1
    start_frame();
    send_frame(32'h1234_5678, 1'b1, 1'b0, -1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);

    // Reload 0xFFFF_FFFF: old key must hold with key_valid high until CHECK resolves
    start_frame();
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b1, 32'h1234_5678, 1'b1, 1'b1);
    @(negedge clk);

    // load_start pulsed on bit 5 of 0x0F0F_00FF (16 ones) must be ignored
    start_frame();
    send_frame(32'h0F0F_00FF, 1'b0, 1'b0, 5, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
